// File: rtl/shift_register_param.sv
// ---------------------------------------------------------------------------
// shift_register_param
//
// Parametrised bidirectional shift register with parallel load, single-step
// shifts and counter-driven multi-step shifts of up to WIDTH places.
//
// Optional build macro: SHREG_ARITH_EN
//   defined   : mode 10 is arithmetic (right replicates MSB, left fills 0)
//   undefined : mode 10 behaves as mode 00 (serial-in); no sign logic built
//
// Ports
//   Clk        in   1      clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   load       in   1      parallel load D (also aborts a running batch)
//   D          in   WIDTH  parallel load data
//   shift_en   in   1      single shift this cycle (IDLE only)
//   dir        in   1      0 = right (toward bit 0), 1 = left (toward MSB)
//   mode       in   2      00 serial-in, 01 rotate, 10 arithmetic, 11 zero-fill
//   shift_in   in   1      serial input bit (mode 00, sampled live)
//   start      in   1      begin a multi-step shift of 'amount' places
//   amount     in   CNT_W  shift count, saturated at WIDTH
//   busy       out  1      multi-step shift in progress
//   done       out  1      one-cycle pulse when a batch completes
//   shift_out  out  1      bit about to leave the register
//   Data_Out   out  WIDTH  register contents
//   state_dbg  out  1      current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: start is accepted only in IDLE on a rising edge (busy low);
// busy is high for exactly N cycles while shifts happen; done pulses for one
// cycle after the final shift (or the cycle after a start with N=0). start
// and shift_en are ignored while busy; busy and done are never both high.
// ---------------------------------------------------------------------------
module shift_register_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             shift_en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             shift_in,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic             shift_out,
    output logic [WIDTH-1:0] Data_Out,
    output logic             state_dbg
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_l;
    logic [1:0]       mode_l;
    logic [CNT_W-1:0] n_eff;

    // Requests larger than the register collapse to a full-width batch.
    assign n_eff = (amount > WIDTH_C) ? WIDTH_C : amount;

    // One-place shift of v in direction d using fill rule m.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [WIDTH-1:0] v,
        input logic             d,
        input logic [1:0]       m,
        input logic             sin
    );
        logic fill;
        logic out_bit;
        out_bit = d ? v[WIDTH-1] : v[0];
        case (m)
            2'b00: fill = sin;
            2'b01: fill = out_bit;
`ifdef SHREG_ARITH_EN
            2'b10: fill = d ? 1'b0 : v[WIDTH-1];
`else
            2'b10: fill = sin;
`endif
            default: fill = 1'b0;
        endcase
        return d ? {v[WIDTH-2:0], fill} : {fill, v[WIDTH-1:1]};
    endfunction

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            Data_Out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            dir_l    <= 1'b0;
            mode_l   <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        Data_Out <= D;
                    end else if (start) begin
                        // Accepting edge only latches the batch; no shift yet.
                        dir_l  <= dir;
                        mode_l <= mode;
                        if (n_eff == '0) begin
                            done <= 1'b1;
                        end else begin
                            cnt   <= n_eff;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end else if (shift_en) begin
                        Data_Out <= shift_one(Data_Out, dir, mode, shift_in);
                    end
                end
                RUN: begin
                    if (load) begin
                        // Abort: take the new data, no completion pulse.
                        Data_Out <= D;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        Data_Out <= shift_one(Data_Out, dir_l, mode_l, shift_in);
                        cnt      <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Live dir in IDLE, latched dir while a batch runs.
    assign shift_out = ((state == RUN) ? dir_l : dir) ? Data_Out[WIDTH-1] : Data_Out[0];
    assign state_dbg = state;

endmodule

// File: tb/tb_shift_register_param.sv
module tb_shift_register_param;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             Clk;
    logic             reset_n;
    logic             load;
    logic [WIDTH-1:0] D;
    logic             shift_en;
    logic             dir;
    logic [1:0]       mode;
    logic             shift_in;
    logic             start;
    logic [CNT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic             shift_out;
    logic [WIDTH-1:0] Data_Out;
    logic             state_dbg;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic [7:0] exp_arith;

    shift_register_param #(.WIDTH(WIDTH)) dut (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .load      (load),
        .D         (D),
        .shift_en  (shift_en),
        .dir       (dir),
        .mode      (mode),
        .shift_in  (shift_in),
        .start     (start),
        .amount    (amount),
        .busy      (busy),
        .done      (done),
        .shift_out (shift_out),
        .Data_Out  (Data_Out),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] val);
        load = 1'b1;
        D    = val;
        tick();
        load = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        load     = 1'b0;
        D        = '0;
        shift_en = 1'b0;
        dir      = 1'b0;
        mode     = 2'b00;
        shift_in = 1'b0;
        start    = 1'b0;
        amount   = '0;

        #2;
        check("reset_data", Data_Out, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_state", state_dbg, 1'b0);
        #10;
        reset_n = 1'b1;
        tick();

        // Single serial-in right shift: B4 -> DA
        do_load(8'hB4);
        check("load_b4", Data_Out, 8'hB4);
        shift_en = 1'b1; dir = 1'b0; mode = 2'b00; shift_in = 1'b1;
        #1;
        check("single_shift_out", shift_out, 1'b0);
        tick();
        shift_en = 1'b0;
        check("single_right_serial", Data_Out, 8'hDA);
        check("single_no_done", done, 1'b0);

        // Rotate left by 3: 81 -> 03 -> 06 -> 0C
        do_load(8'h81);
        start = 1'b1; amount = 4'd3; dir = 1'b1; mode = 2'b01;
        tick();
        start = 1'b0;
        dir = 1'b0; mode = 2'b11;  // live inputs change; latched values must rule
        check("rot_accept_data", Data_Out, 8'h81);
        check("rot_accept_busy", busy, 1'b1);
        check("rot_shift_out_latched", shift_out, 1'b1);
        tick();
        check("rot_s1_data", Data_Out, 8'h03);
        check("rot_s1_busy", busy, 1'b1);
        check("rot_s1_done", done, 1'b0);
        tick();
        check("rot_s2_data", Data_Out, 8'h06);
        check("rot_s2_busy", busy, 1'b1);
        tick();
        check("rot_s3_data", Data_Out, 8'h0C);
        check("rot_s3_busy", busy, 1'b0);
        check("rot_s3_done", done, 1'b1);
        tick();
        check("rot_done_drop", done, 1'b0);
        check("rot_hold", Data_Out, 8'h0C);

        // Mode 10 right by 2 from 90, shift_in = 0
`ifdef SHREG_ARITH_EN
        exp_arith = 8'hE4;
`else
        exp_arith = 8'h24;
`endif
        do_load(8'h90);
        start = 1'b1; amount = 4'd2; dir = 1'b0; mode = 2'b10; shift_in = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mode10_data", Data_Out, {24'h0, exp_arith});
        check("mode10_done", done, 1'b1);

        // amount = 0: done next cycle, no busy, data unchanged
        do_load(8'h5A);
        start = 1'b1; amount = 4'd0; mode = 2'b11;
        tick();
        start = 1'b0;
        check("zero_busy", busy, 1'b0);
        check("zero_done", done, 1'b1);
        check("zero_data", Data_Out, 8'h5A);
        tick();
        check("zero_done_drop", done, 1'b0);
        check("zero_busy_after", busy, 1'b0);

        // amount = 15 saturates to 8 zero-fill right shifts; start in RUN ignored
        do_load(8'hA5);
        start = 1'b1; amount = 4'd15; dir = 1'b0; mode = 2'b11;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 2 || k == 3) begin
                start = 1'b1; amount = 4'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            check($sformatf("sat_data_%0d", k), Data_Out, 32'(8'hA5 >> k));
            check($sformatf("sat_busy_%0d", k), busy, (k < 8) ? 1'b1 : 1'b0);
            check($sformatf("sat_done_%0d", k), done, (k == 8) ? 1'b1 : 1'b0);
        end
        start = 1'b0;
        tick();
        check("sat_done_drop", done, 1'b0);

        // Load during cycle 3 of RUN aborts without a done pulse
        do_load(8'hFF);
        start = 1'b1; amount = 4'd8; dir = 1'b1; mode = 2'b11;
        tick();
        start = 1'b0;
        tick();
        check("abort_s1", Data_Out, 8'hFE);
        tick();
        check("abort_s2", Data_Out, 8'hFC);
        load = 1'b1; D = 8'h3C;
        tick();
        load = 1'b0;
        check("abort_data", Data_Out, 8'h3C);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        tick();
        check("abort_done_later", done, 1'b0);
        check("abort_hold", Data_Out, 8'h3C);

        // Reset mid-RUN takes effect without a clock edge
        do_load(8'h77);
        start = 1'b1; amount = 4'd5; dir = 1'b0; mode = 2'b01;
        tick();
        start = 1'b0;
        tick();
        check("pre_reset_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_reset_data", Data_Out, 8'h00);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_done", done, 1'b0);
        check("async_reset_state", state_dbg, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_done", done, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
